// File: rtl/conv_scan_scheduler.sv
// conv_scan_scheduler: walks an N*N image two pixels at a time, driving a
// dual-lane kernel fetcher and handing each fetched window pair downstream.
//
// Handshakes:
//   - start is a one-cycle request, honoured only in IDLE when abort is low.
//   - fetch_ready is a one-cycle pulse. It is consumed in SETTLE, where it
//     counts down the skip counter, and in CAPTURE, where it strobes
//     win_capture. It is ignored in every other state.
//   - win_valid/win_ready follow strict valid/ready rules. Once win_valid
//     is high, it and win_idx1/win_idx2 stay constant until a rising clock
//     edge where win_ready is also high. That edge is the single transfer.
//   - abort cancels the scan from any non-IDLE state on the next edge.
`timescale 1ns/1ps
module conv_scan_scheduler #(
    parameter int N    = 64,
    parameter int SKIP = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        abort,
    input  logic        fetch_ready,
    output logic [12:0] idx1,
    output logic [12:0] idx2,
    output logic        win_capture,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [12:0] win_idx1,
    output logic [12:0] win_idx2,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Index of the last pair's lane-1 pixel.
    localparam logic [12:0] LAST_IDX = 13'(N * N - 2);
    localparam logic [7:0]  SKIP_V   = 8'(SKIP);

    // With nothing to skip, a new index goes straight to capture.
    localparam state_t FIRST_ST = (SKIP == 0) ? CAPTURE : SETTLE;

    state_t      state_q, state_d;
    logic [12:0] idx1_q, idx1_d;
    logic [7:0]  skip_q, skip_d;
    logic [12:0] widx1_q, widx1_d;
    logic [12:0] widx2_q, widx2_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx1_q  <= 13'd0;
            skip_q  <= 8'd0;
            widx1_q <= 13'd0;
            widx2_q <= 13'd0;
        end else begin
            state_q <= state_d;
            idx1_q  <= idx1_d;
            skip_q  <= skip_d;
            widx1_q <= widx1_d;
            widx2_q <= widx2_d;
        end
    end

    // Next-state logic plus the combinational capture strobe.
    // abort is tested first so it overrides every other input.
    always_comb begin
        state_d     = state_q;
        idx1_d      = idx1_q;
        skip_d      = skip_q;
        widx1_d     = widx1_q;
        widx2_d     = widx2_q;
        win_capture = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            idx1_d  = 13'd0;
            skip_d  = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = FIRST_ST;
                        idx1_d  = 13'd0;
                        skip_d  = SKIP_V;
                    end
                end
                SETTLE: begin
                    if (fetch_ready) begin
                        skip_d = (skip_q == 8'd0) ? 8'd0 : skip_q - 8'd1;
                        if (skip_q <= 8'd1) begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (fetch_ready) begin
                        win_capture = 1'b1;
                        widx1_d     = idx1_q;
                        widx2_d     = {idx1_q[12:1], 1'b1};
                        state_d     = HOLD;
                    end
                end
                HOLD: begin
                    if (win_ready) begin
                        if (idx1_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx1_d  = idx1_q + 13'd2;
                            skip_d  = SKIP_V;
                            state_d = FIRST_ST;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    idx1_d  = 13'd0;
                    skip_d  = 8'd0;
                end
                default: begin
                    state_d = IDLE;
                    idx1_d  = 13'd0;
                    skip_d  = 8'd0;
                end
            endcase
        end
    end

    // idx1 is always even, so lane 2 is idx1 with its low bit set.
    assign idx1      = idx1_q;
    assign idx2      = {idx1_q[12:1], 1'b1};
    assign win_idx1  = widx1_q;
    assign win_idx2  = widx2_q;
    assign win_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_scan_scheduler.sv
// Testbench for conv_scan_scheduler.
// Instances: a 64x64 frame with SKIP=1 (dut) and a 4x4 frame with SKIP=0 (dut0).
// Two scoreboard monitors pop expected window pairs on every valid/ready transfer.
`timescale 1ns/1ps
module tb_conv_scan_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, start, abort, fetch_ready, win_ready;
    logic [12:0] idx1, idx2, win_idx1, win_idx2;
    logic        win_capture, win_valid, busy, done;
    logic [2:0]  dbg_state;

    logic        z_start, z_abort, z_fetch, z_win_ready;
    logic [12:0] z_idx1, z_idx2, z_win_idx1, z_win_idx2;
    logic        z_win_capture, z_win_valid, z_busy, z_done;
    logic [2:0]  z_dbg_state;

    conv_scan_scheduler #(.N(64), .SKIP(1)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .fetch_ready(fetch_ready), .idx1(idx1), .idx2(idx2),
        .win_capture(win_capture), .win_valid(win_valid), .win_ready(win_ready),
        .win_idx1(win_idx1), .win_idx2(win_idx2), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    conv_scan_scheduler #(.N(4), .SKIP(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .start(z_start), .abort(z_abort),
        .fetch_ready(z_fetch), .idx1(z_idx1), .idx2(z_idx2),
        .win_capture(z_win_capture), .win_valid(z_win_valid), .win_ready(z_win_ready),
        .win_idx1(z_win_idx1), .win_idx2(z_win_idx2), .busy(z_busy), .done(z_done),
        .dbg_state(z_dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [25:0] exp_q[$];
    logic [25:0] exp0_q[$];

    int hs_cnt = 0, cap_cnt = 0, done_cnt = 0, done_cyc = 0, hs_cyc = 0;
    int z_hs_cnt = 0, z_cap_cnt = 0, z_done_cnt = 0;

    // fetch_ready generator, one pulse every fr_period cycles while enabled
    logic fr_en = 1'b0;
    int   fr_period = 10;
    int   fr_div = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] pair(input int i);
        logic [12:0] a;
        a = 13'(2 * i);
        return {a, a + 13'd1};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Drive fetch_ready #2 after the edge, clear of the main sequence at #1.
    initial begin
        fetch_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (fr_en) begin
                fr_div++;
                fetch_ready = ((fr_div % fr_period) == 0);
            end else begin
                fr_div      = 0;
                fetch_ready = 1'b0;
            end
        end
    end

    // Scoreboard monitor for the 64x64 instance
    always @(negedge clk) begin
        logic [25:0] e;
        if (n_rst) begin
            if (win_capture) cap_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (win_valid && win_ready) begin
                hs_cnt++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pair_unexpected: got %0d/%0d expected none", win_idx1, win_idx2);
                end else begin
                    e = exp_q.pop_front();
                    check("pair_idx1", int'(win_idx1), int'(e[25:13]));
                    check("pair_idx2", int'(win_idx2), int'(e[12:0]));
                end
            end
        end
    end

    // Scoreboard monitor for the SKIP=0 instance
    always @(negedge clk) begin
        logic [25:0] e;
        if (n_rst) begin
            if (z_win_capture) z_cap_cnt++;
            if (z_done) z_done_cnt++;
            if (z_win_valid && z_win_ready) begin
                z_hs_cnt++;
                if (exp0_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL z_pair_unexpected: got %0d/%0d expected none", z_win_idx1, z_win_idx2);
                end else begin
                    e = exp0_q.pop_front();
                    check("z_pair_idx1", int'(z_win_idx1), int'(e[25:13]));
                    check("z_pair_idx2", int'(z_win_idx2), int'(e[12:0]));
                end
            end
        end
    end

    initial begin
        int nfr, got, g, vdrop, wmove, caps, pulses, imove;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; win_ready = 1'b0;
        z_start = 1'b0; z_abort = 1'b0; z_fetch = 1'b0; z_win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // reset values while n_rst is low
        check("rst_idx1", idx1, 0);
        check("rst_idx2", idx2, 1);
        check("rst_win_idx1", win_idx1, 0);
        check("rst_win_idx2", win_idx2, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_capture", win_capture, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
        n_rst = 1'b1;
        tick(); tick();
        check("idle_busy", busy, 0);

        // full 64x64 frame, fetch_ready every 10 cycles, win_ready held high
        hs_cnt = 0; cap_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 2048; i++) exp_q.push_back(pair(i));
        win_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy", busy, 1);
        fr_en = 1'b1;
        nfr = 0; got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (fetch_ready) nfr++;
            if (win_capture) got = 1;
        end
        check("first_cap_seen", got, 1);
        check("first_cap_on_fr", nfr, 2);
        check("first_cap_idx1", idx1, 0);
        g = 0;
        tick();
        while (done_cnt == 0 && g < 50000) begin
            tick();
            g++;
        end
        check("frame_done_seen", done_cnt, 1);
        check("frame_busy_after_done", busy, 0);
        check("frame_idx1_restored", idx1, 0);
        check("frame_idx2_restored", idx2, 1);
        check("frame_last_win_idx1", win_idx1, 4094);
        check("frame_last_win_idx2", win_idx2, 4095);
        check("frame_done_latency", done_cyc - hs_cyc, 1);
        check("frame_captures", cap_cnt, 2048);
        check("frame_handshakes", hs_cnt, 2048);
        check("frame_queue_empty", exp_q.size(), 0);
        repeat (5) tick();
        check("frame_done_once", done_cnt, 1);
        fr_en = 1'b0;
        tick();

        // downstream stall: win_ready low for 50 cycles in HOLD
        hs_cnt = 0;
        exp_q.push_back(pair(0));
        win_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        fr_en = 1'b1;
        g = 0;
        while (!win_valid && g < 200) begin
            tick();
            g++;
        end
        check("stall_valid_seen", win_valid, 1);
        vdrop = 0; wmove = 0; caps = 0; pulses = 0; imove = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!win_valid) vdrop++;
            if (win_idx1 != 13'd0 || win_idx2 != 13'd1) wmove++;
            if (win_capture) caps++;
            if (fetch_ready) pulses++;
            if (idx1 != 13'd0) imove++;
        end
        check("stall_valid_drops", vdrop, 0);
        check("stall_win_idx_moved", wmove, 0);
        check("stall_captures", caps, 0);
        check("stall_fr_pulses_ge5", int'(pulses >= 5), 1);
        check("stall_idx1_moved", imove, 0);
        tick();
        win_ready = 1'b1;
        tick();
        check("stall_release_hs", hs_cnt, 1);
        check("stall_release_valid", win_valid, 0);
        check("stall_release_idx1", idx1, 2);
        abort = 1'b1; tick(); abort = 1'b0;
        check("stall_abort_busy", busy, 0);
        fr_en = 1'b0;
        tick();

        // abort in SETTLE at pair 100, then restart
        hs_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 100; i++) exp_q.push_back(pair(i));
        start = 1'b1; tick(); start = 1'b0;
        fr_en = 1'b1;
        g = 0;
        while (hs_cnt < 100 && g < 5000) begin
            tick();
            g++;
        end
        check("abort_pre_hs", hs_cnt, 100);
        check("abort_pre_state_settle", dbg_state, 1);
        check("abort_pre_idx1", idx1, 200);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_state", dbg_state, 0);
        check("abort_busy", busy, 0);
        check("abort_idx1", idx1, 0);
        check("abort_idx2", idx2, 1);
        check("abort_win_valid", win_valid, 0);
        repeat (3) tick();
        check("abort_no_done", done_cnt, 0);
        exp_q.push_back(pair(0));
        exp_q.push_back(pair(1));
        start = 1'b1; tick(); start = 1'b0;
        g = 0;
        while (hs_cnt < 102 && g < 500) begin
            tick();
            g++;
        end
        check("restart_hs", hs_cnt, 102);
        check("restart_queue_empty", exp_q.size(), 0);
        abort = 1'b1; tick(); abort = 1'b0;
        fr_en = 1'b0;
        tick();

        // start pulsed during CAPTURE is ignored
        hs_cnt = 0;
        exp_q.push_back(pair(0));
        start = 1'b1; tick(); start = 1'b0;
        fr_en = 1'b1;
        g = 0;
        while (dbg_state != 3'd2 && g < 200) begin
            tick();
            g++;
        end
        check("cap_reached", dbg_state, 2);
        start = 1'b1; tick(); start = 1'b0;
        check("cap_start_ignored_state", dbg_state, 2);
        check("cap_start_ignored_idx1", idx1, 0);
        g = 0;
        while (hs_cnt < 1 && g < 200) begin
            tick();
            g++;
        end
        check("cap_hs", hs_cnt, 1);
        check("cap_after_hs_idx1", idx1, 2);
        check("cap_queue_empty", exp_q.size(), 0);
        abort = 1'b1; tick(); abort = 1'b0;
        fr_en = 1'b0;
        tick();

        // SKIP=0 build, 4x4 frame: the first fetch_ready captures pair 0/1
        for (int i = 0; i < 8; i++) exp0_q.push_back(pair(i));
        z_start = 1'b1; tick(); z_start = 1'b0;
        tick(); tick();
        z_fetch = 1'b1;
        @(negedge clk);
        check("z_first_cap", z_win_capture, 1);
        check("z_first_idx1", z_idx1, 0);
        check("z_first_idx2", z_idx2, 1);
        tick();
        z_fetch = 1'b0;
        check("z_first_valid", z_win_valid, 1);
        check("z_first_win_idx1", z_win_idx1, 0);
        check("z_first_win_idx2", z_win_idx2, 1);
        for (int k = 0; k < 40; k++) begin
            z_fetch = ((k % 4) == 3);
            tick();
        end
        z_fetch = 1'b0;
        tick();
        check("z_captures", z_cap_cnt, 8);
        check("z_handshakes", z_hs_cnt, 8);
        check("z_done_once", z_done_cnt, 1);
        check("z_busy_idle", z_busy, 0);
        check("z_state_idle", z_dbg_state, 0);
        check("z_queue_empty", exp0_q.size(), 0);

        // asynchronous reset while holding pair 2/3
        hs_cnt = 0;
        exp_q.push_back(pair(0));
        exp_q.push_back(pair(1));
        win_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        fr_en = 1'b1;
        g = 0;
        while (hs_cnt < 1 && g < 200) begin
            tick();
            g++;
        end
        win_ready = 1'b0;
        g = 0;
        while (!win_valid && g < 200) begin
            tick();
            g++;
        end
        check("arst_hold_win_idx1", win_idx1, 2);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("arst_idx1", idx1, 0);
        check("arst_idx2", idx2, 1);
        check("arst_win_idx1", win_idx1, 0);
        check("arst_win_idx2", win_idx2, 0);
        check("arst_win_valid", win_valid, 0);
        check("arst_win_capture", win_capture, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        exp_q.delete();
        fr_en = 1'b0;
        tick();
        n_rst = 1'b1;
        repeat (3) tick();
        check("arst_wait_idle", dbg_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_scan_scheduler.md
CONV_SCAN_SCHEDULER -- requirements
Module: conv_scan_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the image side in pixels (N*N pixels, N even).
REQ-002 The block SHALL have parameter SKIP, default 1, giving the number of fetch_ready pulses discarded after each index change.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to scan a frame; honoured only in IDLE.
REQ-006 abort  input  1  synchronous scan cancel.
REQ-007 fetch_ready  input  1  window-complete pulse from the dual kernel fetcher.
REQ-008 idx1  output  13  pixel index driven to fetch lane 1.
REQ-009 idx2  output  13  pixel index driven to fetch lane 2.
REQ-010 win_capture  output  1  one-cycle strobe; downstream latches both fetched 3x3 windows on it.
REQ-011 win_valid  output  1  captured window pair available.
REQ-012 win_ready  input  1  downstream accepts the window pair.
REQ-013 win_idx1, win_idx2  output  13 each  centre indices of the captured pair.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, CAPTURE, HOLD and DONE.
REQ-017 IDLE + start -> SETTLE, with idx1=0, idx2=1 and skip counter loaded with SKIP.
REQ-018 In SETTLE, each fetch_ready SHALL decrement the skip counter; a fetch_ready seen with the counter at 1 SHALL move to CAPTURE; SKIP=0 SHALL go directly to CAPTURE.
REQ-019 In CAPTURE, fetch_ready SHALL assert win_capture combinationally in the same cycle, register win_idx1=idx1 and win_idx2=idx2, and move to HOLD with win_valid=1 on the next cycle.
REQ-020 In HOLD, win_valid SHALL stay high and win_idx1/2 stable until a cycle with win_ready=1; fetch_ready pulses in HOLD SHALL be ignored, with no win_capture.
REQ-021 On win_ready in HOLD, when idx1 is not N*N-2: idx1 and idx2 SHALL each advance by 2, the skip counter SHALL reload to SKIP, win_valid SHALL drop next cycle, and the state SHALL move to SETTLE.
REQ-022 On win_ready in HOLD with idx1=N*N-2, the state SHALL move to DONE, idx1/idx2 SHALL hold their values, and win_valid SHALL drop.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go to IDLE, with idx1=0 and idx2=1 restored.
REQ-024 idx1 and idx2 SHALL change only on the HOLD->SETTLE/DONE transition or on the return to IDLE, and SHALL never change in SETTLE or CAPTURE.
REQ-025 idx2 SHALL always equal idx1+1; idx1 SHALL be even; neither SHALL exceed N*N-1.
REQ-026 abort has priority over all other inputs: in any non-IDLE state it SHALL move to IDLE next cycle, with win_valid=0, idx1=0, idx2=1 and no done pulse.
REQ-027 start in a non-IDLE state SHALL be ignored; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-028 A frame SHALL produce exactly N*N/2 win_capture strobes and N*N/2 accepted handshakes.

Reset
REQ-029 While n_rst=0, the block SHALL be in IDLE with idx1=0, idx2=1, win_idx1=0, win_idx2=0, win_valid=0, win_capture=0, busy=0, done=0 and skip counter=0.
REQ-030 Reset asserted mid-scan SHALL take effect immediately (asynchronously); after release the block SHALL wait in IDLE for start.

Verification
REQ-031 Bench: reset, start, fetch_ready every 10 cycles, win_ready held 1 -> first win_capture on the 2nd fetch_ready; win_idx1=0, win_idx2=1; next pair is 2/3.
REQ-032 Bench: full 64x64 frame -> 2048 captures; last pair win_idx1=4094, win_idx2=4095; done pulses once, 1 cycle after the final handshake; busy falls with it.
REQ-033 Bench: win_ready low for 50 cycles in HOLD -> win_valid stays 1; win_idx stable; no win_capture despite 5 fetch_ready pulses; idx1 unchanged.
REQ-034 Bench: abort in SETTLE at pair 100 -> next cycle IDLE, busy=0, idx1=0, win_valid=0, no done; a new start restarts at pair 0/1.
REQ-035 Bench: start pulsed during CAPTURE -> ignored; SKIP=0 build -> first fetch_ready after start captures pair 0/1.
REQ-036 Bench: n_rst low during HOLD -> all outputs at reset values within the same cycle, with no clock edge needed.
